alu_share_arbiter: RTL
======================

# alu_share_arbiter

Round-robin arbiter and sequencer that shares one AQALU instance between two command requesters. It accepts {opcode, A, B} commands over valid/ready handshakes and drives the ALU operand and opcode inputs from registers. After a programmable settle time it captures the ALU output and returns it on a result handshake, tagged with the source requester. It sits between the top-level pin decode and the ALU so that two command sources (e.g. the switch inputs and a future serial loader) can use the single datapath without contention.

## Interface
Parameters:
- SETTLE, 1: cycles the ALU inputs are held before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_op  in  4  requester 0 opcode.
- req0_a  in  2  requester 0 operand A.
- req0_b  in  2  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- alu_op  out  4  registered opcode to the ALU.
- alu_a  out  2  registered operand A to the ALU.
- alu_b  out  2  registered operand B to the ALU.
- alu_result  in  8  ALU output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  8  captured ALU result.
- res_src  out  1  requester that issued the command (0 or 1).
- busy  out  1  high whenever state is not IDLE.

## Operation
- States:
  - IDLE: waiting for a command.
  - DRIVE: ALU inputs held; settle counter running.
  - HOLD: result presented, waiting for the consumer.
- Grant (IDLE only):
  - One valid requester: it is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - last_grant resets to 1, so requester 0 wins the first contention.
- reqN_ready = (state==IDLE) & grantN. It is combinational from the valids and asserted for at most one requester.
- Requesters must not make valid depend on ready. A requester holds valid, op, a and b stable until accepted.
- Accept (valid & ready at an edge):
  - alu_op/alu_a/alu_b <= command fields.
  - res_src <= granted index; last_grant <= granted index.
  - cnt <= SETTLE-1; state <= DRIVE.
- DRIVE:
  - cnt != 0: cnt decrements.
  - cnt == 0: res_data <= alu_result, res_valid <= 1, state <= HOLD.
- HOLD: on res_valid & res_ready, res_valid <= 0 and state <= IDLE. No new grant happens in that same cycle.
- alu_op/alu_a/alu_b keep the last command after completion. They are not cleared until the next accept.
- Opcode 1111 (running sum) is forwarded like any other opcode. The arbiter samples whatever the ALU presents at capture and adds no special handling.
- All 16 opcodes are passed through unchanged. There is no opcode filtering.

## Timing
- Reset values:
  - req0_ready = req1_ready = 0 (reset forces IDLE with no grant until valids are seen).
  - alu_op = 0, alu_a = 0, alu_b = 0.
  - res_valid = 0, res_data = 0, res_src = 0, busy = 0.
  - Internal: state = IDLE, cnt = 0, last_grant = 1.
- Latency: res_valid rises SETTLE edges after the accept edge.
- Minimum command period is SETTLE+2 cycles:
  - 1 IDLE accept cycle.
  - SETTLE DRIVE cycles.
  - At least 1 HOLD cycle.
- res_ready held low: res_valid, res_data and res_src stay stable indefinitely, and no further commands are accepted.
- res_ready high on the first HOLD cycle: IDLE is reached on the next edge, and a pending request is accepted in that IDLE cycle.
- A requester that deasserts valid before acceptance loses nothing. No command is latched without a handshake.
- Reset mid-DRIVE or mid-HOLD: the operation is aborted, no result is emitted, the command is discarded, and all outputs return to their reset values asynchronously.
- Round-robin guarantee: with both requesters continuously valid, grants strictly alternate 0,1,0,1,...

## Test plan
- Single command, SETTLE=1:
  - Stimulus: req0 op=0111, a=3, b=2; bench ALU model or real AQALU; res_ready=1.
  - Required: req0_ready high in the accept cycle; res_valid one edge later with res_data=0x05, res_src=0; busy falls afterwards.
- Contention after reset:
  - Stimulus: both valid; req0 op=1001, a=3, b=3; req1 op=0000, a=3, b=1; res_ready=1.
  - Required: first result 0x09 with res_src=0, second 0x01 with res_src=1. Grants alternate for 6 back-to-back commands.
- Backpressure:
  - Stimulus: res_ready=0 for 10 cycles after res_valid.
  - Required: res_data stable, both readys 0, busy 1. The result is released on the first res_ready cycle.
- SETTLE=4:
  - Stimulus: req1 op=1011, a=1, b=2 (0110).
  - Required: res_valid rises exactly 4 edges after accept with res_data=0x0C. alu_a/alu_b/alu_op stay constant throughout DRIVE.
- Reset mid-DRIVE:
  - Stimulus: assert rst during DRIVE.
  - Required: res_valid never asserts; all outputs read 0; the next contention grants req0.
- Valid withdrawal:
  - Stimulus: req1_valid pulses while busy, then drops before IDLE.
  - Required: no req1 command is executed and no result is tagged res_src=1.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two command
// requesters. A granted command is registered onto the ALU inputs and held
// for SETTLE cycles. The ALU output is then captured and presented on a
// result handshake, tagged with the index of the requester that issued it.
module alu_share_arbiter #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [1:0] req0_a,
    input  logic [1:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [1:0] req1_a,
    input  logic [1:0] req1_b,
    output logic [3:0] alu_op,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    input  logic [7:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_src,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       last_grant;
    logic       grant0;
    logic       grant1;
    logic       accept;

    // Round-robin choice: a lone requester wins; under contention the one
    // that was not granted last time wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the handshake and busy outputs.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy       = 1'b0;
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 | grant1) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = (req0_ready & req0_valid) | (req1_ready & req1_valid);

    // Datapath: latch the granted command, run the settle count, capture and
    // release the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            res_src    <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            res_data   <= '0;
            res_valid  <= 1'b0;
        end else if (accept) begin
            alu_op     <= grant0 ? req0_op : req1_op;
            alu_a      <= grant0 ? req0_a  : req1_a;
            alu_b      <= grant0 ? req0_b  : req1_b;
            res_src    <= grant1;
            last_grant <= grant1;
            cnt        <= CNT_INIT;
        end else if (state == DRIVE) begin
            if (cnt != '0) begin
                cnt <= cnt - 4'd1;
            end else begin
                res_data  <= alu_result;
                res_valid <= 1'b1;
            end
        end else if (state == HOLD && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
